// File: rtl/pipe_add_sub.sv
// pipe_add_sub
//   Pipelined ripple-carry adder/subtractor with valid/ready flow control.
//   Each pipeline stage resolves one SEG-bit slice of A + B' + c0, passing
//   its carry forward in a register. The operand bits that are not yet
//   added travel down in skew registers. The finished low sum slices travel
//   alongside them, so the full-width result leaves the last stage aligned.
//   Latency is STAGES = WIDTH/SEG cycles and throughput is one beat per cycle.
//   WIDTH must be a multiple of SEG.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high; clears all valid bits and outputs
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle (= pipeline enable, combinational)
//   input1     operand A
//   input2     operand B
//   cin        carry-in, used in add mode only
//   sub        1: A - B, 0: A + B + cin
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   sum        result, modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (in subtract mode, 1 = no borrow)
//   ovf        two's-complement signed overflow
module pipe_add_sub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  // Global stall: the whole pipe advances only when the output slot is free
  // or is being drained this cycle.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
    localparam int LO  = gi * SEG;      // first bit resolved by this stage
    localparam int REM = WIDTH - LO;    // operand bits still unresolved on entry

    logic [REM-1:0]    a_in;
    logic [REM-1:0]    b_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_full;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] sum_q;
    logic              carry_d;
    logic              carry_q;
    logic              valid_d;
    logic              valid_q;

    if (gi == 0) begin : src_g
      // B is inverted and c0 is forced to 1 for subtraction (A + ~B + 1).
      always_comb begin
        a_in  = input1;
        b_in  = sub ? ~input2 : input2;
        c_in  = sub | cin;
        v_in  = in_valid;
        sum_d = seg_full[SEG-1:0];
      end
    end else begin : src_g
      always_comb begin
        a_in  = stage_g[gi-1].skew_g.a_q;
        b_in  = stage_g[gi-1].skew_g.b_q;
        c_in  = stage_g[gi-1].carry_q;
        v_in  = stage_g[gi-1].valid_q;
        sum_d = {seg_full[SEG-1:0], stage_g[gi-1].sum_q};
      end
    end

    always_comb begin
      seg_full = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
      carry_d  = seg_full[SEG];
      valid_d  = v_in;
    end

    // Data registers load only when a real beat arrives. Bubbles therefore
    // never replace the last result with undriven input values.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        if (en) begin
          valid_q <= valid_d;
        end
        if (en && v_in) begin
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end
    end

    if (gi < STAGES - 1) begin : skew_g
      // Upper operand bits waiting for later stages; this includes the MSBs
      // that the final stage needs for the overflow check.
      logic [REM-SEG-1:0] a_d;
      logic [REM-SEG-1:0] b_d;
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_comb begin
        a_d = a_in[REM-1:SEG];
        b_d = b_in[REM-1:SEG];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : tail_g
      // Signed overflow: operands share a sign and the result sign differs.
      logic ovf_d;
      logic ovf_q;

      always_comb begin
        ovf_d = (a_in[REM-1] == b_in[REM-1]) & (seg_full[SEG-1] != a_in[REM-1]);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (en && v_in) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = stage_g[STAGES-1].valid_q;
  assign sum       = stage_g[STAGES-1].sum_q;
  assign cout      = stage_g[STAGES-1].carry_q;
  assign ovf       = stage_g[STAGES-1].tail_g.ovf_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub
//   Directed bench for pipe_add_sub in three configurations: 32/8 (main),
//   16/16 (single stage) and 64/4 (sixteen stages). Inputs are driven on the
//   falling edge and outputs are sampled away from the rising edge.
module tb_pipe_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin_in;
  logic        sub_in;
  logic        out_ready;
  logic        iv32, iv16, iv64;
  logic        ir32, ir16, ir64;
  logic        ov32, ov16, ov64;
  logic        co32, co16, co64;
  logic        of32, of16, of64;
  logic [31:0] s32;
  logic [15:0] s16;
  logic [63:0] s64;

  pipe_add_sub #(.WIDTH(32), .SEG(8)) u32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .input1(a_in[31:0]), .input2(b_in[31:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32)
  );

  pipe_add_sub #(.WIDTH(16), .SEG(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
    .input1(a_in[15:0]), .input2(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16)
  );

  pipe_add_sub #(.WIDTH(64), .SEG(4)) u64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
    .input1(a_in), .input2(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov64), .out_ready(out_ready), .sum(s64), .cout(co64), .ovf(of64)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model for the 32-bit unit: {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
    logic [31:0] bb;
    logic [32:0] r;
    logic        v;
    bb = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {32'd0, (s ? 1'b1 : c)};
    v  = (a[31] == bb[31]) && (r[31] != a[31]);
    return {v, r};
  endfunction

  // One beat into the selected DUT with an empty pipe and out_ready=1. Also
  // measures latency as the number of rising edges from acceptance to out_valid.
  task automatic run_beat(input int which, input string tag,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic s,
                          input logic [63:0] e_sum, input logic e_cout,
                          input logic e_ovf, input int e_lat);
    int          lat;
    logic        got_v;
    logic [63:0] got_sum;
    logic        got_c;
    logic        got_o;
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; sub_in = s; out_ready = 1'b1;
    iv32 = (which == 0); iv16 = (which == 1); iv64 = (which == 2);
    @(posedge clk);
    #1;
    iv32 = 1'b0; iv16 = 1'b0; iv64 = 1'b0;
    a_in = 'x; b_in = 'x; cin_in = 1'bx; sub_in = 1'bx;
    lat = 1;
    got_v = 1'b0; got_sum = '0; got_c = 1'b0; got_o = 1'b0;
    while (lat <= 40) begin
      @(negedge clk);
      case (which)
        0:       begin got_v = ov32; got_sum = {32'd0, s32}; got_c = co32; got_o = of32; end
        1:       begin got_v = ov16; got_sum = {48'd0, s16}; got_c = co16; got_o = of16; end
        default: begin got_v = ov64; got_sum = s64;          got_c = co64; got_o = of64; end
      endcase
      if (got_v) break;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_lat"},  lat,     e_lat);
    chk({tag, "_sum"},  got_sum, e_sum);
    chk({tag, "_cout"}, got_c,   e_cout);
    chk({tag, "_ovf"},  got_o,   e_ovf);
    $display("beat %s: a=0x%0h b=0x%0h cin=%0b sub=%0b -> sum=0x%0h cout=%0b ovf=%0b lat=%0d",
             tag, a, b, c, s, got_sum, got_c, got_o, lat);
  endtask

  initial begin
    logic [33:0] exp_q[$];
    logic [33:0] e;
    logic        need_new;
    logic        fire_in;
    logic        fire_out;
    int          sent;
    int          rcvd;
    int          cyc;
    int          seen;

    reset = 1'b1; out_ready = 1'b0;
    iv32 = 1'b0; iv16 = 1'b0; iv64 = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov32, 1'b0);
    chk("rst_sum",       s32,  32'd0);
    chk("rst_cout",      co32, 1'b0);
    chk("rst_ovf",       of32, 1'b0);
    chk("rst_in_ready",  ir32, 1'b1);
    chk("rst_out_valid64", ov64, 1'b0);
    reset = 1'b0;

    // Directed beats on the 32/8 unit.
    run_beat(0, "add_wrap",  64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0,        1'b1, 1'b0, 4);
    run_beat(0, "sub_5m7",   64'h5,        64'h7, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0, 4);
    run_beat(0, "sub_7m5",   64'h7,        64'h5, 1'b0, 1'b1, 64'h2,        1'b1, 1'b0, 4);
    run_beat(0, "add_ovf",   64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, 4);
    run_beat(0, "sub_ovf",   64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1, 4);
    run_beat(0, "add_cin",   64'h00FF00FF, 64'h0F0F0F0F, 1'b1, 1'b0, 64'h100E100F, 1'b0, 1'b0, 4);
    run_beat(0, "sub_cinig", 64'hA,        64'h3, 1'b1, 1'b1, 64'h7,        1'b1, 1'b0, 4);

    // Single-stage and deep configurations: carry crosses every segment.
    run_beat(1, "w16_wrap", 64'hFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1);
    run_beat(2, "w64_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 16);

    // Stall: the result must hold and in_ready must stay low while unconsumed.
    @(negedge clk);
    a_in = 64'h12345678; b_in = 64'h11111111; cin_in = 1'b0; sub_in = 1'b0;
    out_ready = 1'b0; iv32 = 1'b1;
    @(posedge clk);
    #1 iv32 = 1'b0;
    cyc = 0;
    while (!ov32 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("stall_valid", ov32, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", ir32, 1'b0);
      chk("stall_sum",      s32,  32'h23456789);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_drained", ov32, 1'b0);
    $display("beat stall: sum=0x23456789 held 3 cycles then drained");

    // 16 random beats against random back-pressure, checked through a scoreboard.
    sent = 0; rcvd = 0; cyc = 0; need_new = 1'b1;
    while (rcvd < 16 && cyc < 400) begin
      @(negedge clk);
      if (sent < 16) begin
        if (need_new) begin
          a_in   = {32'd0, $urandom()};
          b_in   = {32'd0, $urandom()};
          cin_in = 1'($urandom_range(0, 1));
          sub_in = 1'($urandom_range(0, 1));
          need_new = 1'b0;
        end
        iv32 = 1'b1;
      end else begin
        iv32 = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rand_in_ready", ir32, !(ov32 && !out_ready));
      fire_in  = iv32 && ir32;
      fire_out = ov32 && out_ready;
      if (fire_out) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("rand_result", {of32, co32, s32}, e);
          $display("beat rand%0d: sum=0x%08h cout=%0b ovf=%0b expected sum=0x%08h cout=%0b ovf=%0b",
                   rcvd, s32, co32, of32, e[31:0], e[32], e[33]);
          rcvd++;
        end
      end
      if (fire_in) begin
        exp_q.push_back(model32(a_in[31:0], b_in[31:0], cin_in, sub_in));
        sent++;
        need_new = 1'b1;
      end
      @(posedge clk);
      cyc++;
    end
    #1 iv32 = 1'b0;
    chk("rand_count", rcvd, 16);

    // Three beats in flight, then a one-cycle reset: none may emerge.
    @(negedge clk);
    out_ready = 1'b0; iv32 = 1'b1; sub_in = 1'b0; cin_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in = 64'h0BAD0000 + 64'(i); b_in = 64'h1;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    iv32 = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flight_valid", ov32, 1'b0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    chk("rst_flight_no_stale", seen, 0);
    $display("beat reset_in_flight: stale beats seen=%0d", seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
